// File: rtl/clz_clo_unit.sv
`default_nettype none
// ============================================================================
// Module   : clz_clo_unit
// Purpose  : Multi-cycle leading-zero / leading-one counter with zero flag,
//            scanning the operand CHUNK bits per cycle.
// Revision : 1.0
// ============================================================================
module clz_clo_unit #(
    parameter int  WIDTH = 32,
    parameter int  CHUNK = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] source,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(NCHUNK - 1);
    localparam logic [CW-1:0] c_chunk    = CW'(CHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work,  w_work_nxt;
    logic [IW-1:0]    r_idx,   w_idx_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic             r_zero,  w_zero_nxt;

    logic [CHUNK-1:0] w_top;
    logic             w_hit;
    logic [CW-1:0]    w_lz;
    logic             w_seen;

    assign w_top = r_work[WIDTH-1 -: CHUNK];
    assign w_hit = |w_top;

    // Leading zeros inside the top chunk; only meaningful when w_hit is set.
    always_comb begin
        w_lz   = '0;
        w_seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!w_seen) begin
                if (w_top[i]) begin
                    w_seen = 1'b1;
                end else begin
                    w_lz = w_lz + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_zero_nxt  = r_zero;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    // CLO is folded into CLZ by inverting the operand once.
                    w_work_nxt  = mode ? ~source : source;
                    w_zero_nxt  = ~|source;
                    w_count_nxt = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = SCAN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    w_count_nxt = r_count + w_lz;
                    w_state_nxt = DONE;
                end else begin
                    w_count_nxt = r_count + c_chunk;
                    w_work_nxt  = r_work << CHUNK;
                    w_idx_nxt   = r_idx + IW'(1);
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            r_zero  <= w_zero_nxt;
        end
    end

    assign busy  = (r_state == SCAN);
    assign done  = (r_state == DONE);
    assign count = r_count;
    assign zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_clz_clo_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_clz_clo_unit
// Purpose  : Directed and random self-checking bench for clz_clo_unit over
//            several WIDTH/CHUNK configurations.
// Revision : 1.0
// ============================================================================
module tb_clz_clo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [63:0] src;

    logic [5:0] bsy, dn, zr;
    logic [6:0] cnt [6];
    logic [5:0] c0, c1, c2, c3;
    logic [3:0] c4;
    logic [6:0] c5;

    int n_cmp = 0;
    int n_err = 0;

    int         lat [6];
    logic [6:0] res [6];
    logic       rz  [6];

    always #5 clk = ~clk;

    // u_d0..u_d3: WIDTH=32 with CHUNK 4,1,2,8; u_d4: 8/1; u_d5: 64/8
    clz_clo_unit #(.WIDTH(32), .CHUNK(4)) u_d0 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src[31:0]), .busy(bsy[0]), .done(dn[0]), .count(c0), .zero(zr[0]));
    clz_clo_unit #(.WIDTH(32), .CHUNK(1)) u_d1 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src[31:0]), .busy(bsy[1]), .done(dn[1]), .count(c1), .zero(zr[1]));
    clz_clo_unit #(.WIDTH(32), .CHUNK(2)) u_d2 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src[31:0]), .busy(bsy[2]), .done(dn[2]), .count(c2), .zero(zr[2]));
    clz_clo_unit #(.WIDTH(32), .CHUNK(8)) u_d3 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src[31:0]), .busy(bsy[3]), .done(dn[3]), .count(c3), .zero(zr[3]));
    clz_clo_unit #(.WIDTH(8),  .CHUNK(1)) u_d4 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src[7:0]),  .busy(bsy[4]), .done(dn[4]), .count(c4), .zero(zr[4]));
    clz_clo_unit #(.WIDTH(64), .CHUNK(8)) u_d5 (.clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .source(src),       .busy(bsy[5]), .done(dn[5]), .count(c5), .zero(zr[5]));

    assign cnt[0] = {1'b0, c0};
    assign cnt[1] = {1'b0, c1};
    assign cnt[2] = {1'b0, c2};
    assign cnt[3] = {1'b0, c3};
    assign cnt[4] = {3'b0, c4};
    assign cnt[5] = c5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leading run of bits equal to m, scanning down from bit w-1.
    function automatic int lead_ref(input logic [63:0] v, input int w, input logic m);
        int n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i] != m) break;
            n++;
        end
        return n;
    endfunction

    function automatic int lat_ref(input int l, input int w, input int c);
        int k = (l + c) / c;
        if (k > w / c) k = w / c;
        return k + 1;
    endfunction

    // Drives start for one rising edge; returns #1 after that edge.
    task automatic pulse_start(input logic [63:0] s, input logic m);
        @(negedge clk);
        src   = s;
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency counts the start edge, so a done seen after edge n gives n+1.
    task automatic run_all(input logic [63:0] s, input logic m);
        bit all_done;
        pulse_start(s, m);
        for (int i = 0; i < 6; i++) begin
            lat[i] = 0;
            res[i] = '0;
            rz[i]  = 1'b0;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (lat[i] == 0 && dn[i]) begin
                    lat[i] = cyc + 1;
                    res[i] = cnt[i];
                    rz[i]  = zr[i];
                end
                if (lat[i] == 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         l;
        logic [6:0] r;
        bit         seen;
        logic [63:0] v;
        logic        m;
        int          chunks [4];

        chunks = '{4, 1, 2, 8};
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        src   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {58'b0, bsy}, 64'h0);
        chk("rst_done",  {58'b0, dn},  64'h0);
        chk("rst_count", cnt[0], 0);
        chk("rst_zero",  {58'b0, zr},  64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_all(64'h8000_0000, 1'b0);
        chk("clz_msb_count", res[0], 0);
        chk("clz_msb_lat",   lat[0], 2);
        chk("clz_msb_zero",  rz[0],  0);

        run_all(64'h0, 1'b0);
        chk("clz_zero_count", res[0], 32);
        chk("clz_zero_lat",   lat[0], 9);
        chk("clz_zero_zero",  rz[0],  1);
        chk("w64_zero_count", res[5], 64);
        chk("w8_zero_count",  res[4], 8);

        run_all(64'h0001_2345, 1'b0);
        chk("clz_mid_count", res[0], 15);
        chk("clz_mid_lat",   lat[0], 5);
        chk("clz_mid_zero",  rz[0],  0);

        run_all(64'hFFFF_FFFF, 1'b1);
        chk("clo_all_count", res[0], 32);
        chk("clo_all_lat",   lat[0], 9);
        chk("clo_all_zero",  rz[0],  0);

        run_all(64'hF000_0000, 1'b1);
        chk("clo_f_count", res[0], 4);
        chk("clo_f_lat",   lat[0], 3);

        repeat (3) @(posedge clk);
        #1;
        chk("hold_count", cnt[0], 4);
        chk("hold_done",  dn[0],  0);
        chk("hold_busy",  bsy[0], 0);

        run_all(64'h1, 1'b0);
        chk("w8c1_count",  res[4], 7);
        chk("w8c1_lat",    lat[4], 9);
        chk("w64c8_count", res[5], 63);
        chk("w64c8_lat",   lat[5], 9);
        chk("w32c4_count", res[0], 31);

        // A second start mid-scan must not disturb the first operand.
        pulse_start(64'h1, 1'b0);
        l = 0;
        r = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                @(negedge clk);
                src   = 64'h8000_0000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (cyc == 3) start = 1'b0;
            if (dn[0] && l == 0) begin
                l = cyc + 1;
                r = cnt[0];
            end
        end
        chk("ignore_lat",   l, 9);
        chk("ignore_count", r, 31);

        pulse_start(64'h8000_0000, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_done1",  dn[0],  1);
        chk("b2b_count1", cnt[0], 0);
        src   = 64'h0001_2345;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_nogap_busy", bsy[0], 1);
        chk("b2b_nogap_done", dn[0],  0);
        l = 0;
        r = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (dn[0] && l == 0) begin
                l = cyc + 1;
                r = cnt[0];
            end
        end
        chk("b2b_lat2",   l, 5);
        chk("b2b_count2", r, 15);

        pulse_start(64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  bsy[0], 0);
        chk("abort_done",  dn[0],  0);
        chk("abort_count", cnt[0], 0);
        chk("abort_zero",  zr[0],  0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dn[0]) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        for (int n = 0; n < 24; n++) begin
            v = {32'h0, $urandom() >> $urandom_range(0, 31)};
            m = 1'($urandom_range(0, 1));
            if (m) v[31:0] = ~v[31:0];
            run_all(v, m);
            for (int j = 0; j < 4; j++) begin
                l = lead_ref(v, 32, m);
                chk($sformatf("rand_count_c%0d", chunks[j]), res[j], l);
                chk($sformatf("rand_lat_c%0d", chunks[j]), lat[j], lat_ref(l, 32, chunks[j]));
            end
            chk("rand_zero", rz[0], (v[31:0] == 32'h0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
